// File: rtl/sync_fifo_pkg.sv
// Shared helpers for the first-word-fall-through FIFO: read latency
// selection and the sizes that follow from it.
package sync_fifo_pkg;

  // RAM read latency: "TRUE" adds the RAM output register (2 cycles).
  function automatic int lat_of(input string output_reg);
    return (output_reg == "TRUE") ? 2 : 1;
  endfunction

  function automatic int depth_of(input int addr_width);
    return 1 << addr_width;
  endfunction

  // Sizes for the default configuration (ADDR_WIDTH=9, OUTPUT_REG="TRUE").
  localparam int DEPTH      = depth_of(9);
  localparam int SKID_DEPTH = lat_of("TRUE") + 1;
  localparam int CNT_W      = 9 + 1;

endpackage

// File: rtl/sync_fifo_fwft_skid.sv
// Small circular output buffer that holds words already read out of the
// RAM. Its head entry is the FIFO's m_data.
module fifo_skid_buf
  import sync_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 3
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           wr_en,
  input  logic [DATA_WIDTH-1:0]          wr_data,
  input  logic                           rd_en,
  output logic [DATA_WIDTH-1:0]          rd_data,
  output logic [$clog2(DEPTH+1)-1:0]     cnt
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]         head;
  logic [PW-1:0]         tail;

  // Depth is usually not a power of two, so wrap explicitly.
  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign rd_data = mem[head];

  // Capture and pop may share an edge; cnt then stays put. Entries are
  // cleared on reset so the exposed head reads zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      head <= '0;
      tail <= '0;
      cnt  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (wr_en) begin
        mem[tail] <= wr_data;
        tail      <= nxt(tail);
      end
      if (rd_en) head <= nxt(head);
      cnt <= cnt + CW'(wr_en) - CW'(rd_en);
    end
  end

endmodule

// File: rtl/sync_fifo_fwft.sv
// Single-clock FWFT FIFO: inferred dual-port RAM with 1- or 2-cycle read
// latency, a prefetch skid buffer hiding that latency, occupancy count,
// threshold flags and a sticky overflow flag.
module sync_fifo_fwft
  import sync_fifo_pkg::*;
#(
  parameter int    DATA_WIDTH      = 8,
  parameter int    ADDR_WIDTH      = 9,
  parameter string OUTPUT_REG      = "TRUE",
  parameter int    ALMOST_FULL_TH  = (1 << ADDR_WIDTH) - 4,
  parameter int    ALMOST_EMPTY_TH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] s_data,
  input  logic                  s_valid,
  output logic                  s_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic                  overflow
);

  localparam int LAT        = lat_of(OUTPUT_REG);
  localparam int FIFO_DEPTH = depth_of(ADDR_WIDTH);
  localparam int SKID_SLOTS = LAT + 1;
  localparam int CNT_BITS   = ADDR_WIDTH + 1;
  localparam int SKW        = $clog2(SKID_SLOTS + 1);
  localparam int OCC_W      = SKW + 2;

  logic [DATA_WIDTH-1:0] ram [FIFO_DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic [CNT_BITS-1:0]   ram_cnt;
  logic [CNT_BITS-1:0]   count_nxt;
  logic                  push;
  logic                  pop;
  logic                  re;
  logic                  vld_p0;
  logic                  vld_p1;
  logic [DATA_WIDTH-1:0] rd_data_p0;
  logic [DATA_WIDTH-1:0] rd_data_p1;
  logic                  cap_vld;
  logic [DATA_WIDTH-1:0] cap_data;
  logic [SKW-1:0]        skid_cnt;
  logic [1:0]            inflight;
  logic [OCC_W-1:0]      occ;

  assign s_ready = !rst && (count < CNT_BITS'(FIFO_DEPTH));
  assign push    = s_valid && s_ready;
  assign m_valid = (skid_cnt != '0);
  assign pop     = m_valid && m_ready;

  // Skid slots claimed once this read lands: current entries (less the one
  // popped on this edge), reads still in flight, and the new read. Crediting
  // the pop is what lets a read issue every cycle in steady state.
  assign inflight = {1'b0, vld_p0} + ((LAT == 2) ? {1'b0, vld_p1} : 2'd0);
  assign occ      = OCC_W'(skid_cnt) - OCC_W'(pop) + OCC_W'(inflight) + OCC_W'(1);
  assign re       = (ram_cnt != '0) && (occ <= OCC_W'(SKID_SLOTS));

  assign count_nxt = count + CNT_BITS'(push) - CNT_BITS'(pop);

  // ---- write port ----
  // RAM write; a word written here is readable from the next edge on.
  always_ff @(posedge clk) begin
    if (push) ram[wr_ptr] <= s_data;
  end

  // ---- read stage p0 / p1 ----
  // RAM read register, then the optional output register (free-running).
  always_ff @(posedge clk) begin
    if (re) rd_data_p0 <= ram[rd_ptr];
    rd_data_p1 <= rd_data_p0;
  end

  // Pointers, RAM occupancy and the in-flight valid shift register.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      ram_cnt <= '0;
      vld_p0  <= 1'b0;
      vld_p1  <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
      if (re)   rd_ptr <= rd_ptr + ADDR_WIDTH'(1);
      ram_cnt <= ram_cnt + CNT_BITS'(push) - CNT_BITS'(re);
      vld_p0  <= re;
      vld_p1  <= vld_p0;
    end
  end

  // ---- skid capture ----
  assign cap_vld  = (LAT == 2) ? vld_p1 : vld_p0;
  assign cap_data = (LAT == 2) ? rd_data_p1 : rd_data_p0;

  fifo_skid_buf #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (SKID_SLOTS)
  ) u_skid (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (cap_vld),
    .wr_data (cap_data),
    .rd_en   (pop),
    .rd_data (m_data),
    .cnt     (skid_cnt)
  );

  // Occupancy and flags, registered from the next count so they move together.
  always_ff @(posedge clk) begin
    if (rst) begin
      count        <= '0;
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
      overflow     <= 1'b0;
    end else begin
      count        <= count_nxt;
      almost_full  <= (count_nxt >= CNT_BITS'(ALMOST_FULL_TH));
      almost_empty <= (count_nxt <= CNT_BITS'(ALMOST_EMPTY_TH));
      if (s_valid && !s_ready) overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_sync_fifo_fwft.sv
// Bench for sync_fifo_fwft: instance 0 uses OUTPUT_REG="TRUE", instance 1
// uses "FALSE"; both see identical stimulus and each has its own queue model.
module tb_sync_fifo_fwft;

  localparam int DEPTH = 512;
  localparam int AF_TH = 508;
  localparam int AE_TH = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       s_valid = 1'b0;
  logic       m_ready = 1'b0;
  logic [7:0] s_data = 8'h00;

  wire [1:0]       s_ready_w, m_valid_w, af_w, ae_w, ov_w;
  wire [1:0][7:0]  m_data_w;
  wire [1:0][9:0]  count_w;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  sync_fifo_fwft #(.DATA_WIDTH(8), .ADDR_WIDTH(9), .OUTPUT_REG("TRUE"),
                   .ALMOST_FULL_TH(AF_TH), .ALMOST_EMPTY_TH(AE_TH)) dut_reg (
    .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready_w[0]),
    .m_data(m_data_w[0]), .m_valid(m_valid_w[0]), .m_ready(m_ready), .count(count_w[0]),
    .almost_full(af_w[0]), .almost_empty(ae_w[0]), .overflow(ov_w[0]));

  sync_fifo_fwft #(.DATA_WIDTH(8), .ADDR_WIDTH(9), .OUTPUT_REG("FALSE"),
                   .ALMOST_FULL_TH(AF_TH), .ALMOST_EMPTY_TH(AE_TH)) dut_noreg (
    .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready_w[1]),
    .m_data(m_data_w[1]), .m_valid(m_valid_w[1]), .m_ready(m_ready), .count(count_w[1]),
    .almost_full(af_w[1]), .almost_empty(ae_w[1]), .overflow(ov_w[1]));

  task automatic chk(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s[%0d]: got 0x%0h, expected 0x%0h at %0t", name, k, act, exp, $time);
  endtask

  // Reference model per instance: a plain queue of accepted words.
  for (genvar k = 0; k < 2; k++) begin : g_mon
    logic [7:0] q[$];
    logic [7:0] outq[$];
    int         sz;
    int         pushes = 0;
    logic       ovf = 1'b0;
    logic       hold = 1'b0;
    logic [7:0] hold_data = 8'h00;

    always @(negedge clk) begin
      sz = q.size();
      chk("count", k, count_w[k], sz);
      chk("s_ready", k, s_ready_w[k], (!rst && sz < DEPTH));
      chk("almost_full", k, af_w[k], (sz >= AF_TH));
      chk("almost_empty", k, ae_w[k], (sz <= AE_TH));
      chk("overflow", k, ov_w[k], ovf);
      if (sz == 0) chk("m_valid_empty", k, m_valid_w[k], 0);
      else if (m_valid_w[k]) chk("head_data", k, m_data_w[k], q[0]);
      if (hold) begin
        chk("hold_valid", k, m_valid_w[k], 1);
        chk("hold_data", k, m_data_w[k], hold_data);
      end
      if (rst) begin
        q.delete();
        ovf  = 1'b0;
        hold = 1'b0;
      end else begin
        hold      = m_valid_w[k] && !m_ready;
        hold_data = m_data_w[k];
        if (s_valid && sz >= DEPTH) ovf = 1'b1;
        if (m_valid_w[k] && m_ready && sz != 0) begin
          outq.push_back(m_data_w[k]);
          void'(q.pop_front());
        end
        if (s_valid && sz < DEPTH) begin
          q.push_back(s_data);
          pushes++;
        end
      end
    end
  end

  typedef struct {
    logic       sv;
    logic [7:0] sd;
    logic       mr;
    int         cnt0;
    int         cnt1;
    logic       mv0;
    logic       mv1;
    logic [7:0] md;
  } vec_t;

  vec_t tbl[6];

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1; s_valid = 1'b0; m_ready = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int n, b0, b1;

    // single 0xA5 push into an empty FIFO with m_ready held high
    tbl[0] = '{1'b1, 8'hA5, 1'b1, 0, 0, 1'b0, 1'b0, 8'hA5};
    tbl[1] = '{1'b0, 8'h00, 1'b1, 1, 1, 1'b0, 1'b0, 8'hA5};
    tbl[2] = '{1'b0, 8'h00, 1'b1, 1, 1, 1'b0, 1'b0, 8'hA5};
    tbl[3] = '{1'b0, 8'h00, 1'b1, 1, 1, 1'b0, 1'b1, 8'hA5};
    tbl[4] = '{1'b0, 8'h00, 1'b1, 1, 0, 1'b1, 1'b0, 8'hA5};
    tbl[5] = '{1'b0, 8'h00, 1'b1, 0, 0, 1'b0, 1'b0, 8'hA5};

    // reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      chk("rst_count", k, count_w[k], 0);
      chk("rst_m_valid", k, m_valid_w[k], 0);
      chk("rst_m_data", k, m_data_w[k], 0);
      chk("rst_almost_empty", k, ae_w[k], 1);
      chk("rst_almost_full", k, af_w[k], 0);
      chk("rst_overflow", k, ov_w[k], 0);
      chk("rst_s_ready", k, s_ready_w[k], 0);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 2; k++) chk("release_s_ready", k, s_ready_w[k], 1);
    @(posedge clk); #1;

    // latency table
    for (int i = 0; i < 6; i++) begin
      s_valid = tbl[i].sv; s_data = tbl[i].sd; m_ready = tbl[i].mr;
      @(negedge clk);
      chk("tbl_count", 0, count_w[0], tbl[i].cnt0);
      chk("tbl_count", 1, count_w[1], tbl[i].cnt1);
      chk("tbl_m_valid", 0, m_valid_w[0], tbl[i].mv0);
      chk("tbl_m_valid", 1, m_valid_w[1], tbl[i].mv1);
      if (tbl[i].mv0) chk("tbl_m_data", 0, m_data_w[0], tbl[i].md);
      if (tbl[i].mv1) chk("tbl_m_data", 1, m_data_w[1], tbl[i].md);
      @(posedge clk); #1;
    end

    // fill to full with m_ready low
    do_reset();
    m_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      s_valid = 1'b1; s_data = i[7:0];
      @(negedge clk);
      chk("fill_count", 0, count_w[0], i);
      chk("fill_almost_full", 0, af_w[0], (i >= AF_TH));
      @(posedge clk); #1;
    end
    s_valid = 1'b1; s_data = 8'hFF;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      chk("full_count", k, count_w[k], DEPTH);
      chk("full_s_ready", k, s_ready_w[k], 0);
      chk("full_almost_full", k, af_w[k], 1);
      chk("full_overflow_pre", k, ov_w[k], 0);
    end
    @(posedge clk); #1;
    s_valid = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      chk("overflow_set", k, ov_w[k], 1);
      chk("overflow_count", k, count_w[k], DEPTH);
    end
    g_mon[0].outq.delete();
    g_mon[1].outq.delete();
    @(posedge clk); #1;
    m_ready = 1'b1;
    n = 0;
    while (n < 2000 && (g_mon[0].outq.size() < DEPTH || g_mon[1].outq.size() < DEPTH)) begin
      @(posedge clk); n++;
    end
    @(negedge clk);
    chk("drain_size", 0, g_mon[0].outq.size(), DEPTH);
    chk("drain_size", 1, g_mon[1].outq.size(), DEPTH);
    for (int i = 0; i < g_mon[0].outq.size(); i++) chk("drain_order", 0, g_mon[0].outq[i], i & 255);
    for (int i = 0; i < g_mon[1].outq.size(); i++) chk("drain_order", 1, g_mon[1].outq[i], i & 255);
    chk("drain_count", 0, count_w[0], 0);
    chk("drain_count", 1, count_w[1], 0);

    // continuous streaming, one word per cycle
    do_reset();
    @(negedge clk);
    for (int k = 0; k < 2; k++) chk("reset_clears_overflow", k, ov_w[k], 0);
    @(posedge clk); #1;
    s_valid = 1'b1; m_ready = 1'b1;
    for (int c = 0; c < 2000; c++) begin
      s_data = 8'($urandom);
      @(negedge clk);
      if (c >= 6) begin
        chk("stream_m_valid", 0, m_valid_w[0], 1);
        chk("stream_m_valid", 1, m_valid_w[1], 1);
        chk("stream_count", 0, count_w[0], 4);
        chk("stream_count", 1, count_w[1], 3);
      end
      @(posedge clk); #1;
    end
    s_valid = 1'b0;
    n = 0;
    while (n < 100 && (count_w[0] != 0 || count_w[1] != 0)) begin
      @(posedge clk); n++;
    end
    @(negedge clk);
    chk("stream_drained", 0, count_w[0], 0);
    chk("stream_drained", 1, count_w[1], 0);
    @(posedge clk); #1;

    // random handshakes
    do_reset();
    b0 = g_mon[0].pushes;
    b1 = g_mon[1].pushes;
    n = 0;
    while (n < 60000 && (g_mon[0].pushes - b0 < 10000 || g_mon[1].pushes - b1 < 10000)) begin
      s_valid = 1'($urandom_range(0, 1));
      m_ready = 1'($urandom_range(0, 1));
      s_data  = 8'($urandom);
      @(posedge clk); #1;
      n++;
    end
    chk("random_pushes", 0, (g_mon[0].pushes - b0 >= 10000), 1);
    chk("random_pushes", 1, (g_mon[1].pushes - b1 >= 10000), 1);
    s_valid = 1'b0; m_ready = 1'b1;
    n = 0;
    while (n < 3000 && (count_w[0] != 0 || count_w[1] != 0)) begin
      @(posedge clk); n++;
    end
    @(negedge clk);
    chk("random_drained", 0, count_w[0], 0);
    chk("random_drained", 1, count_w[1], 0);
    @(posedge clk); #1;

    // reset mid-stream with 100 words stored
    do_reset();
    m_ready = 1'b0; s_valid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      s_data = 8'($urandom);
      @(posedge clk); #1;
    end
    s_valid = 1'b0;
    @(negedge clk);
    chk("stored_100", 0, count_w[0], 100);
    chk("stored_100", 1, count_w[1], 100);
    @(posedge clk); #1;
    rst = 1'b1; s_valid = 1'b1; m_ready = 1'b1; s_data = 8'h77;
    @(posedge clk); #1;
    rst = 1'b0; s_valid = 1'b0; m_ready = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      chk("midrst_count", k, count_w[k], 0);
      chk("midrst_m_valid", k, m_valid_w[k], 0);
      chk("midrst_overflow", k, ov_w[k], 0);
      chk("midrst_s_ready", k, s_ready_w[k], 1);
    end
    g_mon[0].outq.delete();
    g_mon[1].outq.delete();
    @(posedge clk); #1;
    s_valid = 1'b1; s_data = 8'h11; m_ready = 1'b1;
    @(posedge clk); #1;
    s_data = 8'h22;
    @(posedge clk); #1;
    s_valid = 1'b0;
    n = 0;
    while (n < 20 && (g_mon[0].outq.size() < 2 || g_mon[1].outq.size() < 2)) begin
      @(posedge clk); n++;
    end
    @(negedge clk);
    chk("post_rst_size", 0, g_mon[0].outq.size(), 2);
    chk("post_rst_size", 1, g_mon[1].outq.size(), 2);
    if (g_mon[0].outq.size() >= 2) begin
      chk("post_rst_word0", 0, g_mon[0].outq[0], 8'h11);
      chk("post_rst_word1", 0, g_mon[0].outq[1], 8'h22);
    end
    if (g_mon[1].outq.size() >= 2) begin
      chk("post_rst_word0", 1, g_mon[1].outq[0], 8'h11);
      chk("post_rst_word1", 1, g_mon[1].outq[1], 8'h22);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
